// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
//   Byte FIFO in the UART echo path. Every rx_ready strobe from uart_rx is
//   captured into a DEPTH-entry buffer. A small read FSM drains the buffer into
//   uart_tx using the tx_start/tx_busy handshake. Bytes that arrive while the
//   buffer is full are dropped and counted.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   rx_ready     : one-cycle strobe, rx_data holds a received byte
//   rx_data      : received byte
//   tx_busy      : uart_tx busy flag
//   tx_start     : transmit request, held until tx_busy is seen high
//   tx_data      : byte for uart_tx, stable while tx_start is high
//   count        : bytes stored (0..DEPTH), post-edge value
//   empty / full : count == 0 / count == DEPTH
//   overflow     : one-cycle pulse when a byte is dropped
//   drop_cnt     : saturating dropped-byte counter (sticks at 255)
//   dbg_state    : read FSM state (0 IDLE, 1 SEND, 2 DRAIN)
//
// Handshake: tx_start rises in IDLE only when a byte is queued and tx_busy is
// low. It stays high, with tx_data frozen, until tx_busy is sampled high; that
// edge pops the byte. The FSM then waits for tx_busy to fall before it may
// start the next byte.
module uart_echo_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_ready,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic [7:0]        drop_cnt,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push;
   logic              pop;
   logic              drop;
   logic              load;
   logic              tx_start_nxt;
   logic [ADDR_W:0]   count_nxt;

   // A pop on the same edge frees a slot, so a full FIFO can still accept.
   assign push      = rx_ready && (!full || pop);
   assign drop      = rx_ready && full && !pop;
   assign dbg_state = state;

   always_comb begin
      state_nxt    = state;
      tx_start_nxt = tx_start;
      load         = 1'b0;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               load         = 1'b1;
               tx_start_nxt = 1'b1;
               state_nxt    = SEND;
            end
         end
         SEND: begin
            if (tx_busy) begin
               pop          = 1'b1;
               tx_start_nxt = 1'b0;
               state_nxt    = DRAIN;
            end
         end
         DRAIN: begin
            if (!tx_busy) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt    = IDLE;
            tx_start_nxt = 1'b0;
         end
      endcase
   end

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
         drop_cnt <= 8'h00;
      end else begin
         state    <= state_nxt;
         tx_start <= tx_start_nxt;
         if (load) begin
            tx_data <= mem[rd_ptr];
         end
         // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count    <= count_nxt;
         empty    <= (count_nxt == '0);
         full     <= (count_nxt == DEPTH_C);
         overflow <= drop;
         if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule
